// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit.
package mem_pkg;

  // Load controls from EX/MEM.
  localparam logic [2:0] MEM_RD_NONE = 3'b000;
  localparam logic [2:0] MEM_RD_LB   = 3'b001;
  localparam logic [2:0] MEM_RD_LH   = 3'b010;
  localparam logic [2:0] MEM_RD_LW   = 3'b011;
  localparam logic [2:0] MEM_RD_LBU  = 3'b101;
  localparam logic [2:0] MEM_RD_LHU  = 3'b110;

  // Store controls from EX/MEM.
  localparam logic [1:0] MEM_WR_NONE = 2'b00;
  localparam logic [1:0] MEM_WR_SB   = 2'b01;
  localparam logic [1:0] MEM_WR_SH   = 2'b10;
  localparam logic [1:0] MEM_WR_SW   = 2'b11;

  // Access sizes used for the alignment check.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, BUS, DONE} mem_state_t;

  // Only the five defined load codes start an access; the rest mean none.
  function automatic logic is_load_code(input logic [2:0] code);
    return (code == MEM_RD_LB)  || (code == MEM_RD_LH)  || (code == MEM_RD_LW) ||
           (code == MEM_RD_LBU) || (code == MEM_RD_LHU);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ack bus between the MEM stage and the memory.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half of a read word and extends it.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] dmem_rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  mem_read,
  output logic [31:0] load_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select, then sign or zero extension by load type.
  always_comb begin
    byte_sel = 8'h00;
    case (addr)
      2'd0: byte_sel = dmem_rdata[7:0];
      2'd1: byte_sel = dmem_rdata[15:8];
      2'd2: byte_sel = dmem_rdata[23:16];
      2'd3: byte_sel = dmem_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    load_word = 32'h0;
    case (mem_read)
      MEM_RD_LB:  load_word = {{24{byte_sel[7]}}, byte_sel};
      MEM_RD_LBU: load_word = {24'h0, byte_sel};
      MEM_RD_LH:  load_word = {{16{half_sel[15]}}, half_sel};
      MEM_RD_LHU: load_word = {16'h0, half_sel};
      MEM_RD_LW:  load_word = dmem_rdata;
      default:    load_word = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access: req/ack bus cycle, lane steering,
// write strobes, load extension and pipeline stall generation.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 mem_read,
  input  logic [1:0]                 mem_write,
  input  logic [31:0]                alu_result,
  input  logic [31:0]                rd2,
  mem_access_stage_if.master         dmem,
  output logic [31:0]                load_data,
  output logic                       mem_stall,
  output logic                       misalign_err,
  output logic                       bus_err
);

  mem_state_t state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       addr_lo;  // byte offset of the load in flight
  logic [2:0]       rd_op;    // load type of the access in flight

  logic        wr_pend, rd_pend, pending, misaligned;
  logic [1:0]  acc_size;
  logic [3:0]  wstrb_next;
  logic [31:0] wdata_next;
  logic [31:0] load_word;

  // Decode the EX/MEM controls; a store code overrides a load code.
  always_comb begin
    wr_pend  = (mem_write != MEM_WR_NONE);
    rd_pend  = !wr_pend && is_load_code(mem_read);
    pending  = wr_pend || rd_pend;

    acc_size = SZ_BYTE;
    if (wr_pend) begin
      case (mem_write)
        MEM_WR_SH: acc_size = SZ_HALF;
        MEM_WR_SW: acc_size = SZ_WORD;
        default:   acc_size = SZ_BYTE;
      endcase
    end else begin
      case (mem_read)
        MEM_RD_LH, MEM_RD_LHU: acc_size = SZ_HALF;
        MEM_RD_LW:             acc_size = SZ_WORD;
        default:               acc_size = SZ_BYTE;
      endcase
    end

    misaligned = ((acc_size == SZ_HALF) && alu_result[0]) ||
                 ((acc_size == SZ_WORD) && (alu_result[1:0] != 2'b00));
  end

  // Store lane strobes and data replication; loads drive no strobes.
  always_comb begin
    wstrb_next = 4'b0000;
    wdata_next = 32'h0;
    case (mem_write)
      MEM_WR_SB: begin
        wstrb_next = 4'b0001 << alu_result[1:0];
        wdata_next = {4{rd2[7:0]}};
      end
      MEM_WR_SH: begin
        wstrb_next = 4'b0011 << alu_result[1:0];
        wdata_next = {2{rd2[15:0]}};
      end
      MEM_WR_SW: begin
        wstrb_next = 4'b1111;
        wdata_next = rd2;
      end
      default: begin
        wstrb_next = 4'b0000;
        wdata_next = 32'h0;
      end
    endcase
  end

  mem_load_align u_align (
    .dmem_rdata (dmem.dmem_rdata),
    .addr       (addr_lo),
    .mem_read   (rd_op),
    .load_word  (load_word)
  );

  // Hold the upstream pipeline while an access is being accepted or on the bus.
  assign mem_stall = ((state == IDLE) && pending) || (state == BUS);

  // Access FSM with registered bus outputs and error pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      addr_lo         <= 2'b00;
      rd_op           <= MEM_RD_NONE;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'h0;
      dmem.dmem_wdata <= 32'h0;
      dmem.dmem_wstrb <= 4'b0000;
      load_data       <= 32'h0;
      misalign_err    <= 1'b0;
      bus_err         <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            if (misaligned) begin
              // No bus cycle; report and let EX/MEM advance via DONE.
              misalign_err <= 1'b1;
              load_data    <= 32'h0;
              state        <= DONE;
            end else begin
              dmem.dmem_req   <= 1'b1;
              dmem.dmem_we    <= wr_pend;
              dmem.dmem_addr  <= {alu_result[31:2], 2'b00};
              dmem.dmem_wstrb <= wstrb_next;
              dmem.dmem_wdata <= wdata_next;
              addr_lo         <= alu_result[1:0];
              rd_op           <= rd_pend ? mem_read : MEM_RD_NONE;
              wait_cnt        <= '0;
              state           <= BUS;
            end
          end
        end
        BUS: begin
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            if (!dmem.dmem_we) load_data <= load_word;
            state <= DONE;
          end else if (wait_cnt == CNT_W'(MAX_WAIT)) begin
            dmem.dmem_req <= 1'b0;
            bus_err       <= 1'b1;
            load_data     <= 32'h0;
            state         <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          wait_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (built with MAX_WAIT=4).
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mem_read;
  logic [1:0]  mem_write;
  logic [31:0] alu_result, rd2, load_data;
  logic        mem_stall, misalign_err, bus_err;

  mem_access_stage_if bus ();

  mem_access_stage #(.MAX_WAIT(4), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .alu_result   (alu_result),
    .rd2          (rd2),
    .dmem         (bus.master),
    .load_data    (load_data),
    .mem_stall    (mem_stall),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Observations collected per access.
  int          n_stall, n_req, n_mis, n_berr;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_wstrb;
  logic        c_we;

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Present one access from a fresh IDLE cycle; ack on the ack_at-th
  // request cycle (0 = never). Returns in the next IDLE cycle with
  // controls cleared, as EX/MEM would after advancing.
  task automatic run_access(input logic [2:0] rd, input logic [1:0] wr,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] rword, input int ack_at);
    logic done;
    done = 1'b0;
    mem_read = rd; mem_write = wr; alu_result = addr; rd2 = data;
    bus.dmem_ack = 1'b0;
    n_stall = 0; n_req = 0; n_mis = 0; n_berr = 0;
    c_addr = 32'h0; c_wdata = 32'h0; c_wstrb = 4'h0; c_we = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      if (bus.dmem_req) begin
        n_req++;
        if (n_req == 1) begin
          c_addr = bus.dmem_addr; c_wdata = bus.dmem_wdata;
          c_wstrb = bus.dmem_wstrb; c_we = bus.dmem_we;
        end
        if (n_req == ack_at) begin
          bus.dmem_ack = 1'b1; bus.dmem_rdata = rword;
        end
      end
      if (misalign_err) n_mis++;
      if (bus_err) n_berr++;
      if (mem_stall) n_stall++;
      else done = 1'b1;
      if (!done) begin
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL access_complete: stall never released after %0d cycles", n_stall);
    end
    step;
    mem_read = MEM_RD_NONE; mem_write = MEM_WR_NONE;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    mem_read = MEM_RD_NONE; mem_write = MEM_WR_NONE;
    alu_result = 32'h0; rd2 = 32'h0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
    step; step;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.dmem_req, bus.dmem_we, bus.dmem_wstrb, misalign_err, bus_err, mem_stall} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: req=%b we=%b wstrb=%b mis=%b berr=%b stall=%b, need all 0",
               bus.dmem_req, bus.dmem_we, bus.dmem_wstrb, misalign_err, bus_err, mem_stall);
    end
    vectors++;
    if ({bus.dmem_addr, bus.dmem_wdata, load_data} !== 96'h0) begin
      miscompares++;
      $display("FAIL reset_data: addr=%h wdata=%h load=%h, need 0", bus.dmem_addr, bus.dmem_wdata, load_data);
    end
    vectors++;
    if (dut.state !== IDLE) begin
      miscompares++;
      $display("FAIL reset_state: got %0d need IDLE", dut.state);
    end
    step;
  endtask

  task automatic test_lw_wait;
    run_access(MEM_RD_LW, MEM_WR_NONE, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 3);
    vectors++;
    if (c_addr !== 32'h104 || c_wstrb !== 4'b0000 || c_we !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_bus: addr=%h wstrb=%b we=%b need 104/0000/0", c_addr, c_wstrb, c_we);
    end
    vectors++;
    if (n_stall != 4 || n_req != 3) begin
      miscompares++;
      $display("FAIL lw_timing: stall=%0d req=%0d need 4/3", n_stall, n_req);
    end
    vectors++;
    if (load_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL lw_data: got %h need deadbeef", load_data);
    end
  endtask

  task automatic test_byte_loads;
    run_access(MEM_RD_LB, MEM_WR_NONE, 32'h0000_0203, 32'h0, 32'h80FF_1234, 1);
    vectors++;
    if (load_data !== 32'hFFFF_FF80 || n_stall != 2 || c_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL lb: data=%h stall=%0d addr=%h need ffffff80/2/200", load_data, n_stall, c_addr);
    end
    run_access(MEM_RD_LBU, MEM_WR_NONE, 32'h0000_0203, 32'h0, 32'h80FF_1234, 1);
    vectors++;
    if (load_data !== 32'h0000_0080) begin
      miscompares++;
      $display("FAIL lbu: got %h need 00000080", load_data);
    end
  endtask

  task automatic test_stores;
    run_access(MEM_RD_NONE, MEM_WR_SH, 32'h0000_0012, 32'h1234_ABCD, 32'h0, 1);
    vectors++;
    if (c_we !== 1'b1 || c_wstrb !== 4'b1100 || c_wdata !== 32'hABCD_ABCD || c_addr !== 32'h10) begin
      miscompares++;
      $display("FAIL sh_bus: we=%b wstrb=%b wdata=%h addr=%h need 1/1100/abcdabcd/10",
               c_we, c_wstrb, c_wdata, c_addr);
    end
    vectors++;
    if (n_stall != 2 || load_data !== 32'h0000_0080) begin
      miscompares++;
      $display("FAIL sh_misc: stall=%0d load=%h need 2/00000080", n_stall, load_data);
    end
    run_access(MEM_RD_NONE, MEM_WR_SB, 32'h0000_0001, 32'hFFFF_FF55, 32'h0, 1);
    vectors++;
    if (c_wstrb !== 4'b0010 || c_wdata !== 32'h5555_5555) begin
      miscompares++;
      $display("FAIL sb_bus: wstrb=%b wdata=%h need 0010/55555555", c_wstrb, c_wdata);
    end
    // Both codes present: store wins.
    run_access(MEM_RD_LW, MEM_WR_SW, 32'h0000_0020, 32'hCAFE_F00D, 32'h1111_1111, 1);
    vectors++;
    if (c_we !== 1'b1 || c_wstrb !== 4'b1111 || c_wdata !== 32'hCAFE_F00D || load_data !== 32'h0000_0080) begin
      miscompares++;
      $display("FAIL sw_over_lw: we=%b wstrb=%b wdata=%h load=%h need 1/1111/cafef00d/00000080",
               c_we, c_wstrb, c_wdata, load_data);
    end
  endtask

  task automatic test_half_loads;
    run_access(MEM_RD_LH, MEM_WR_NONE, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 1);
    vectors++;
    if (load_data !== 32'hFFFF_8001) begin
      miscompares++;
      $display("FAIL lh: got %h need ffff8001", load_data);
    end
    run_access(MEM_RD_LHU, MEM_WR_NONE, 32'h0000_0000, 32'h0, 32'h8001_8FFF, 1);
    vectors++;
    if (load_data !== 32'h0000_8FFF) begin
      miscompares++;
      $display("FAIL lhu: got %h need 00008fff", load_data);
    end
  endtask

  task automatic test_misalign;
    run_access(MEM_RD_LW, MEM_WR_NONE, 32'h0000_0006, 32'h0, 32'h0, 1);
    vectors++;
    if (n_req != 0 || n_mis != 1 || n_stall != 1 || load_data !== 32'h0) begin
      miscompares++;
      $display("FAIL misalign_lw: req=%0d mis=%0d stall=%0d load=%h need 0/1/1/0",
               n_req, n_mis, n_stall, load_data);
    end
    @(negedge clk);
    vectors++;
    if (misalign_err !== 1'b0) begin
      miscompares++;
      $display("FAIL misalign_pulse: still %b one cycle later, need 0", misalign_err);
    end
  endtask

  task automatic test_invalid_code;
    mem_read = 3'b100; mem_write = MEM_WR_NONE; alu_result = 32'h40;
    @(negedge clk);
    vectors++;
    if (mem_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL invalid_code: stall=%b need 0", mem_stall);
    end
    step;
    mem_read = MEM_RD_NONE;
  endtask

  task automatic test_timeout;
    run_access(MEM_RD_LW, MEM_WR_NONE, 32'h0000_0100, 32'h0, 32'h0, 0);
    vectors++;
    if (n_req != 5 || n_berr != 1 || n_stall != 6 || load_data !== 32'h0) begin
      miscompares++;
      $display("FAIL timeout: req=%0d berr=%0d stall=%0d load=%h need 5/1/6/0",
               n_req, n_berr, n_stall, load_data);
    end
    // Late ack two cycles after the abort.
    step;
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
    step;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (load_data !== 32'h0 || bus.dmem_req !== 1'b0 || bus_err !== 1'b0 || dut.state !== IDLE) begin
      miscompares++;
      $display("FAIL late_ack: load=%h req=%b berr=%b state=%0d need 0/0/0/IDLE",
               load_data, bus.dmem_req, bus_err, dut.state);
    end
    step;
  endtask

  task automatic test_reset_in_bus;
    // Leave a nonzero load result so clearing is visible.
    run_access(MEM_RD_LHU, MEM_WR_NONE, 32'h0000_0002, 32'h0, 32'h8001_0000, 1);
    mem_read = MEM_RD_LW; alu_result = 32'h0000_0040;
    step;          // IDLE -> BUS
    step;          // second BUS cycle
    @(negedge clk);
    vectors++;
    if (bus.dmem_req !== 1'b1 || load_data !== 32'h0000_8001) begin
      miscompares++;
      $display("FAIL rst_bus_pre: req=%b load=%h need 1/00008001", bus.dmem_req, load_data);
    end
    rst = 1'b0; mem_read = MEM_RD_NONE;
    step;
    vectors++;
    if (bus.dmem_req !== 1'b0 || dut.state !== IDLE || load_data !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_bus: req=%b state=%0d load=%h need 0/IDLE/0", bus.dmem_req, dut.state, load_data);
    end
    rst = 1'b1;
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1234_5678;
    step;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    vectors++;
    if (load_data !== 32'h0 || mem_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_bus_ack: load=%h stall=%b need 0/0", load_data, mem_stall);
    end
  endtask

  initial begin
    test_reset;
    test_lw_wait;
    test_byte_loads;
    test_stores;
    test_misalign;
    test_half_loads;
    test_invalid_code;
    test_timeout;
    test_reset_in_bus;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM-stage data-memory access unit, directly downstream of the EX/MEM pipeline register. It takes the registered mem_read/mem_write controls, ALU address and store data, and runs a req/ack transaction on the data-memory bus. It performs byte-lane steering, write strobes and load sign/zero extension. It stalls the pipeline until the access completes and hands the load data to the MEM/WB register.

Parameters:
MAX_WAIT, 255, cycles dmem_req may stay asserted without dmem_ack before the access is aborted with bus_err
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT

Ports:
clk  in  1  single clock, all state changes on the rising edge
rst  in  1  reset, synchronous, active-low: sampled on the rising edge of clk, state cleared when rst==0
mem_read  in  3  from EX/MEM: 000 none, 001 lb, 010 lh, 011 lw, 101 lbu, 110 lhu; other codes are treated as none
mem_write  in  2  from EX/MEM: 00 none, 01 sb, 10 sh, 11 sw
alu_result  in  32  byte address of the access
rd2  in  32  store data, right-aligned
dmem_req  out  1  bus request, registered
dmem_we  out  1  1 = store
dmem_addr  out  32  word-aligned address, alu_result with bits [1:0] forced to 00
dmem_wdata  out  32  store data replicated into the addressed lanes
dmem_wstrb  out  4  byte-lane write strobes; 0000 on loads
dmem_ack  in  1  bus completion, valid only while dmem_req==1
dmem_rdata  in  32  read word, valid with dmem_ack
load_data  out  32  extended load result to MEM/WB, registered
mem_stall  out  1  combinational; 1 holds PC, IF/ID, ID/EX and EX/MEM
misalign_err  out  1  one-cycle pulse on a misaligned access
bus_err  out  1  one-cycle pulse on a bus timeout

Behaviour:
- Reset (rst==0 at a rising edge): state IDLE; dmem_req, dmem_we, misalign_err and bus_err are 0; dmem_addr, dmem_wdata and load_data are 0; dmem_wstrb is 0000; wait counter is 0. Any outstanding transaction is dropped.
- access_pending = (mem_read valid code) OR (mem_write != 00). If both a load and a store code are present, the store wins and the load is ignored.
- Misaligned means: half access with addr[0]==1, or word access with addr[1:0]!=00.
- FSM states: IDLE, BUS, DONE.
- IDLE, no access pending: stay in IDLE.
- IDLE, aligned access pending: register address, strobes, wdata and we; set dmem_req=1; go to BUS.
- IDLE, misaligned access pending: no bus cycle is issued; misalign_err=1 for one cycle; load_data=0; go to DONE.
- BUS, dmem_ack==1: drop dmem_req; on a load, capture the extended dmem_rdata into load_data; go to DONE.
- BUS, no ack and counter==MAX_WAIT: drop dmem_req; bus_err=1 for one cycle; load_data=0; go to DONE. Otherwise the counter increments each cycle.
- DONE: unconditionally go to IDLE next cycle; counter is cleared.
- mem_stall = (state==IDLE AND access_pending) OR state==BUS. It is 0 in DONE, so EX/MEM advances exactly once per access.
- Latency: 2 cycles of stall for an ack in the first BUS cycle; plus k for k extra wait cycles.
- Store strobes: sb 0001<<addr[1:0]; sh 0011<<addr[1:0]; sw 1111.
- Store data replication: sb {4{rd2[7:0]}}; sh {2{rd2[15:0]}}; sw rd2.
- Load extension: the byte/half is selected by addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- load_data holds its value until the next completed load, error or reset.
- dmem_ack outside BUS is ignored, including a late ack after a timeout or reset.
- Reset asserted while in BUS drops dmem_req on the same edge; no ack is then captured.

Decomposition:
- Shared package mem_pkg holds:
  - MEM_RD_* constants: NONE, LB, LH, LW, LBU, LHU.
  - MEM_WR_* constants: NONE, SB, SH, SW.
  - The mem_state_t enum: IDLE, BUS, DONE.
- One combinational sub-module, mem_load_align: inputs dmem_rdata, addr[1:0] and mem_read; output the 32-bit extended value.
- Strobe and wdata generation stays inline in mem_access_stage.

Test Plan:
- lw, addr 0x0000_0104, rdata 0xDEADBEEF, ack on the 3rd BUS cycle -> dmem_addr=0x104, wstrb=0000, mem_stall high 4 cycles, load_data=0xDEADBEEF.
- lb and then lbu, addr 0x0000_0203, rdata 0x80FF_1234 -> lb gives load_data=0xFFFF_FF80; lbu gives 0x0000_0080.
- sh, addr 0x0000_0012, rd2 0x1234_ABCD, immediate ack -> we=1, wstrb=1100, wdata=0xABCD_ABCD, 2 stall cycles.
- lw at addr 0x0000_0006 -> no dmem_req, misalign_err pulses once, load_data=0, mem_stall high 1 cycle.
- lw with MAX_WAIT=4 and no ack -> dmem_req high 5 cycles, bus_err pulses once, then IDLE; an ack 2 cycles later is ignored.
- rst=0 on the 2nd BUS cycle -> the next edge gives dmem_req=0, state IDLE, load_data=0; an ack in the following cycle does not change load_data.
